// File: rtl/buzzer_alarm_seq.sv
// Alarm sequencer: ADC threshold with hysteresis and confirm count, gating a
// repeating beep/pause pattern on buzzer_en for the downstream PWM stage.
module buzzer_alarm_seq #(
    parameter int unsigned SAMPLE_W        = 12,
    parameter int unsigned TICK_CYCLES     = 100_000,
    parameter int unsigned ON_TICKS        = 100,
    parameter int unsigned OFF_TICKS       = 100,
    parameter int unsigned PAUSE_TICKS     = 500,
    parameter int unsigned BEEP_COUNT      = 3,
    parameter int unsigned CONFIRM_SAMPLES = 4,
    parameter int unsigned HYST            = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] threshold,
    input  logic                mute,
    output logic                buzzer_en,
    output logic                alarm_active,
    output logic                muted
);

    localparam int unsigned CONF_W    = $clog2(CONFIRM_SAMPLES + 1);
    localparam int unsigned PRE_W     = $clog2(TICK_CYCLES + 1);
    localparam int unsigned MAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_ON_OFF > PAUSE_TICKS) ? MAX_ON_OFF : PAUSE_TICKS;
    localparam int unsigned TICK_W    = $clog2(MAX_TICKS + 1);
    localparam int unsigned BEEP_W    = $clog2(BEEP_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BEEP_ON  = 2'd1,
        BEEP_OFF = 2'd2,
        PAUSE    = 2'd3
    } state_t;

    state_t              state;
    logic [CONF_W-1:0]   confirm_cnt;
    logic [PRE_W-1:0]    pre_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [BEEP_W-1:0]   beep_idx;
    logic [SAMPLE_W-1:0] clear_lvl;
    logic [TICK_W-1:0]   state_limit;
    logic                qualify;
    logic                below_clear;
    logic                pre_wrap;
    logic                state_done;

    // Sample classification against threshold and hysteresis clear level
    always_comb begin
        clear_lvl   = '0;
        if (threshold >= SAMPLE_W'(HYST))
            clear_lvl = threshold - SAMPLE_W'(HYST);
        qualify     = sample_valid && (sample >= threshold);
        below_clear = sample_valid && (sample < clear_lvl);
    end

    // Last cycle of the current pattern state
    always_comb begin
        state_limit = '0;
        case (state)
            BEEP_ON:  state_limit = TICK_W'(ON_TICKS - 1);
            BEEP_OFF: state_limit = TICK_W'(OFF_TICKS - 1);
            PAUSE:    state_limit = TICK_W'(PAUSE_TICKS - 1);
            default:  state_limit = '0;
        endcase
        pre_wrap   = (pre_cnt == PRE_W'(TICK_CYCLES - 1));
        state_done = pre_wrap && (tick_cnt == state_limit);
    end

    // Alarm condition, confirm counter and mute acknowledge
    always_ff @(posedge clk) begin
        if (reset) begin
            confirm_cnt  <= '0;
            alarm_active <= 1'b0;
            muted        <= 1'b0;
        end else if (qualify) begin
            if (confirm_cnt < CONF_W'(CONFIRM_SAMPLES))
                confirm_cnt <= confirm_cnt + CONF_W'(1);
            if (confirm_cnt >= CONF_W'(CONFIRM_SAMPLES - 1))
                alarm_active <= 1'b1;
            if (mute && alarm_active)
                muted <= 1'b1;
        end else if (below_clear) begin
            confirm_cnt  <= '0;
            alarm_active <= 1'b0;
            muted        <= 1'b0;
        end else if (mute && alarm_active) begin
            muted <= 1'b1;
        end
    end

    // Beep pattern FSM; timers restart on every state entry
    always_ff @(posedge clk) begin
        if (reset || !alarm_active || muted) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            tick_cnt  <= '0;
            beep_idx  <= '0;
            buzzer_en <= 1'b0;
        end else if (state == IDLE) begin
            state     <= BEEP_ON;
            pre_cnt   <= '0;
            tick_cnt  <= '0;
            beep_idx  <= '0;
            buzzer_en <= 1'b1;
        end else if (state_done) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
            case (state)
                BEEP_ON: begin
                    buzzer_en <= 1'b0;
                    if (beep_idx < BEEP_W'(BEEP_COUNT - 1))
                        state <= BEEP_OFF;
                    else
                        state <= PAUSE;
                end
                BEEP_OFF: begin
                    state     <= BEEP_ON;
                    beep_idx  <= beep_idx + BEEP_W'(1);
                    buzzer_en <= 1'b1;
                end
                default: begin
                    state     <= BEEP_ON;
                    beep_idx  <= '0;
                    buzzer_en <= 1'b1;
                end
            endcase
        end else begin
            pre_cnt <= pre_wrap ? '0 : pre_cnt + PRE_W'(1);
            if (pre_wrap)
                tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

endmodule

// File: tb/tb_buzzer_alarm_seq.sv
// Bench for buzzer_alarm_seq: scenario tasks plus randomized traffic compared
// cycle by cycle against a behavioural model of the alarm and beep pattern.
module tb_buzzer_alarm_seq;

    localparam int TC      = 4;
    localparam int ON      = 2;
    localparam int OFF     = 1;
    localparam int PAUSE_T = 3;
    localparam int BEEPS   = 2;
    localparam int CONFIRM = 2;
    localparam int HYST    = 16;
    localparam int PERIOD  = BEEPS * ON * TC + (BEEPS - 1) * OFF * TC + PAUSE_T * TC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic [11:0] thr = 12'd1000;
    logic        mute = 1'b0;
    logic        buzzer_en;
    logic        alarm_active;
    logic        muted;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_alarm = 0;
    bit m_muted = 0;
    bit m_bz    = 0;
    bit m_run   = 0;
    int m_conf  = 0;
    int m_p     = 0;

    buzzer_alarm_seq #(
        .SAMPLE_W(12), .TICK_CYCLES(TC), .ON_TICKS(ON), .OFF_TICKS(OFF),
        .PAUSE_TICKS(PAUSE_T), .BEEP_COUNT(BEEPS), .CONFIRM_SAMPLES(CONFIRM), .HYST(HYST)
    ) dut (
        .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
        .threshold(thr), .mute(mute), .buzzer_en(buzzer_en),
        .alarm_active(alarm_active), .muted(muted)
    );

    always #5 clk = ~clk;

    // Buzzer level at cycle p of a running pattern (p=0 is the first high cycle)
    function automatic bit pat_on(input int p);
        int q = p % PERIOD;
        for (int b = 0; b < BEEPS; b++) begin
            if (q >= b * (ON + OFF) * TC && q < b * (ON + OFF) * TC + ON * TC)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs about to be sampled
    task automatic model_step();
        bit old_al = m_alarm;
        int clr = (int'(thr) >= HYST) ? int'(thr) - HYST : 0;
        if (reset) begin
            m_alarm = 0; m_muted = 0; m_bz = 0; m_run = 0; m_conf = 0; m_p = 0;
        end else begin
            if (!m_alarm || m_muted) begin
                m_run = 0; m_bz = 0;
            end else if (!m_run) begin
                m_run = 1; m_p = 0; m_bz = 1;
            end else begin
                m_p++; m_bz = pat_on(m_p);
            end
            if (sample_valid && int'(sample) >= int'(thr)) begin
                if (m_conf < CONFIRM) m_conf++;
                if (m_conf == CONFIRM) m_alarm = 1;
                if (mute && old_al) m_muted = 1;
            end else if (sample_valid && int'(sample) < clr) begin
                m_alarm = 0; m_conf = 0; m_muted = 0;
            end else if (mute && old_al) begin
                m_muted = 1;
            end
        end
    endtask

    // One clock with the given inputs; returns 1 ns after the edge
    task automatic apply(input bit v, input int s, input bit m, input bit r);
        @(negedge clk);
        sample_valid = v;
        sample       = 12'(s);
        mute         = m;
        reset        = r;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(0, 0, 0, 1);
        apply(0, 0, 0, 1);
        checks++;
        if ({buzzer_en, alarm_active, muted} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got bz/al/mu=%b%b%b required 000", buzzer_en, alarm_active, muted);
        end
        apply(0, 0, 0, 0);
    endtask

    task automatic test_raise_pattern();
        int highs = 0;
        thr = 12'd1000;
        apply(1, 1200, 0, 0);
        checks++;
        if (alarm_active !== 1'b0) begin
            errors++; $display("FAIL raise_early: alarm_active=%b required 0", alarm_active);
        end
        apply(1, 1200, 0, 0);
        checks++;
        if (alarm_active !== 1'b1 || buzzer_en !== 1'b0) begin
            errors++; $display("FAIL raise_edge: al/bz=%b%b required 10", alarm_active, buzzer_en);
        end
        for (int i = 0; i < 2 * PERIOD; i++) begin
            apply(0, 0, 0, 0);
            if (buzzer_en === 1'b1) highs++;
            checks++;
            if ({buzzer_en, alarm_active, muted} !== {m_bz, m_alarm, m_muted}) begin
                errors++;
                $display("FAIL pattern cyc%0d: got bz/al/mu=%b%b%b required %b%b%b", i,
                         buzzer_en, alarm_active, muted, m_bz, m_alarm, m_muted);
            end
        end
        checks++;
        if (highs != 2 * BEEPS * ON * TC) begin
            errors++; $display("FAIL pattern_duty: high cycles=%0d required %0d", highs, 2 * BEEPS * ON * TC);
        end
    endtask

    task automatic test_confirm_break();
        apply(0, 0, 0, 1);
        apply(1, 1200, 0, 0);
        apply(1, 900, 0, 0);
        apply(1, 1200, 0, 0);
        checks++;
        if (alarm_active !== 1'b0 || m_alarm !== 1'b0) begin
            errors++; $display("FAIL confirm_break: alarm_active=%b required 0", alarm_active);
        end
        apply(1, 1200, 0, 0);
        checks++;
        if (alarm_active !== 1'b1) begin
            errors++; $display("FAIL confirm_reraise: alarm_active=%b required 1", alarm_active);
        end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 4; i++) apply(0, 0, 0, 0);
        apply(1, 990, 0, 0);
        checks++;
        if (alarm_active !== 1'b1 || buzzer_en !== m_bz) begin
            errors++; $display("FAIL hyst_band: al/bz=%b%b required 1%b", alarm_active, buzzer_en, m_bz);
        end
        apply(1, 983, 0, 0);
        checks++;
        if (alarm_active !== 1'b0) begin
            errors++; $display("FAIL hyst_clear: alarm_active=%b required 0", alarm_active);
        end
        apply(0, 0, 0, 0);
        checks++;
        if (buzzer_en !== 1'b0 || {alarm_active, muted} !== {m_alarm, m_muted}) begin
            errors++; $display("FAIL hyst_buzz_off: bz/al/mu=%b%b%b required 000", buzzer_en, alarm_active, muted);
        end
    endtask

    task automatic test_mute();
        apply(1, 1200, 0, 0);
        apply(1, 1200, 0, 0);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0);
        apply(0, 0, 1, 0);
        checks++;
        if (muted !== 1'b1 || alarm_active !== 1'b1) begin
            errors++; $display("FAIL mute_set: mu/al=%b%b required 11", muted, alarm_active);
        end
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, 0);
            checks++;
            if ({buzzer_en, alarm_active, muted} !== 3'b011) begin
                errors++; $display("FAIL mute_silent cyc%0d: bz/al/mu=%b%b%b required 011", i, buzzer_en, alarm_active, muted);
            end
        end
        apply(1, 900, 0, 0);
        checks++;
        if (muted !== 1'b0 || alarm_active !== 1'b0) begin
            errors++; $display("FAIL mute_clear: mu/al=%b%b required 00", muted, alarm_active);
        end
        apply(1, 1200, 0, 0);
        apply(1, 1200, 0, 0);
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 0, 0);
            checks++;
            if ({buzzer_en, alarm_active, muted} !== {m_bz, m_alarm, m_muted}) begin
                errors++; $display("FAIL mute_resume cyc%0d: bz/al/mu=%b%b%b required %b%b%b", i,
                                   buzzer_en, alarm_active, muted, m_bz, m_alarm, m_muted);
            end
        end
    endtask

    task automatic test_mute_clear_same();
        apply(1, 900, 1, 0);
        checks++;
        if (muted !== 1'b0 || alarm_active !== 1'b0) begin
            errors++; $display("FAIL mute_vs_clear: mu/al=%b%b required 00", muted, alarm_active);
        end
        apply(0, 0, 1, 0);
        apply(0, 0, 0, 0);
        checks++;
        if ({buzzer_en, alarm_active, muted} !== 3'b000) begin
            errors++; $display("FAIL mute_idle: bz/al/mu=%b%b%b required 000", buzzer_en, alarm_active, muted);
        end
    endtask

    task automatic test_reset_mid_pause();
        apply(1, 1200, 0, 0);
        apply(1, 1200, 0, 0);
        for (int i = 0; i < 25; i++) apply(0, 0, 0, 0);
        checks++;
        if (buzzer_en !== 1'b0 || alarm_active !== 1'b1 || m_bz !== 1'b0) begin
            errors++; $display("FAIL pause_reached: bz/al=%b%b required 01", buzzer_en, alarm_active);
        end
        apply(0, 0, 0, 1);
        checks++;
        if ({buzzer_en, alarm_active, muted} !== 3'b000) begin
            errors++; $display("FAIL reset_mid_pause: bz/al/mu=%b%b%b required 000", buzzer_en, alarm_active, muted);
        end
        apply(1, 1200, 0, 0);
        checks++;
        if (alarm_active !== 1'b0) begin
            errors++; $display("FAIL post_reset_one: alarm_active=%b required 0", alarm_active);
        end
        apply(1, 1200, 0, 0);
        checks++;
        if (alarm_active !== 1'b1) begin
            errors++; $display("FAIL post_reset_two: alarm_active=%b required 1", alarm_active);
        end
    endtask

    task automatic test_back_to_back();
        apply(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            apply(1, 970 + int'($urandom_range(0, 60)), ($urandom_range(0, 40) == 0), 0);
            checks++;
            if ({buzzer_en, alarm_active, muted} !== {m_bz, m_alarm, m_muted}) begin
                errors++; $display("FAIL back_to_back cyc%0d: bz/al/mu=%b%b%b required %b%b%b", i,
                                   buzzer_en, alarm_active, muted, m_bz, m_alarm, m_muted);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 2))
                    0: thr = 12'd1000;
                    1: thr = 12'(HYST / 2);
                    default: thr = 12'($urandom_range(0, 4095));
                endcase
            end
            apply($urandom_range(0, 3) == 0,
                  ($urandom_range(0, 1) == 1) ? int'(thr) - 24 + int'($urandom_range(0, 48))
                                              : int'($urandom_range(0, 4095)),
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 499) == 0);
            checks++;
            if ({buzzer_en, alarm_active, muted} !== {m_bz, m_alarm, m_muted}) begin
                errors++; $display("FAIL random cyc%0d: bz/al/mu=%b%b%b required %b%b%b thr=%0d", i,
                                   buzzer_en, alarm_active, muted, m_bz, m_alarm, m_muted, thr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_raise_pattern();
        test_confirm_break();
        test_hysteresis();
        test_mute();
        test_mute_clear_same();
        test_reset_mid_pause();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
